// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: shared state encoding and elaboration helpers for the timer scheduler.
package timer_sched_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  function automatic int PRESC_OF(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/timer_sched_if.sv
// timer_sched_if: requester-side bus of the shared countdown timer.
interface timer_sched_if #(
  parameter int N_REQ = 4,
  parameter int DUR_W = 16
) ();
  logic [N_REQ-1:0]       req_i;
  logic [N_REQ*DUR_W-1:0] dur_i;
  logic [N_REQ-1:0]       gnt_o;
  logic [N_REQ-1:0]       done_o;
  logic                   busy_o;
  logic                   tick_o;
  logic [DUR_W-1:0]       remain_o;
  modport slave (input req_i, dur_i, output gnt_o, done_o, busy_o, tick_o, remain_o);
  modport master (output req_i, dur_i, input gnt_o, done_o, busy_o, tick_o, remain_o);
endinterface

// File: rtl/timer_sched_tick_gen.sv
// tick_gen: free-running prescaler producing a one-cycle strobe at TICK_FREQ.
module tick_gen
  import timer_sched_pkg::*;
#(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int TICK_FREQ = 1000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);
  localparam int PRESC = PRESC_OF(CLK_FREQ, TICK_FREQ);
  localparam int CW = $clog2(PRESC);
  localparam logic [CW-1:0] LAST = CW'(PRESC - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == LAST;
  assign cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/timer_sched.sv
// timer_sched: round-robin sharing of one tick-based countdown timer among N_REQ requesters.
// Define TIMER_SCHED_ABORT_EN to let the owner cancel its run by dropping its request.
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int TICK_FREQ = 1000,
  parameter int N_REQ     = 4,
  parameter int DUR_W     = 16
) (
  input logic           clk_i,
  input logic           rst_ni,
  timer_sched_if.slave  bus
);
  localparam int PRESC = PRESC_OF(CLK_FREQ, TICK_FREQ);
  localparam int IW = idx_w(N_REQ);
  if (PRESC < 2) begin : g_bad_presc
    $error("timer_sched: PRESC must be >= 2");
  end
  if (N_REQ < 2) begin : g_bad_nreq
    $error("timer_sched: N_REQ must be >= 2");
  end
  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d, ptr_q, ptr_d, idx_nxt;
  logic [DUR_W-1:0] remain_q, remain_d;
  logic [IW:0]      pick;
  logic [N_REQ-1:0] onehot;
  logic             tick, abort;
  tick_gen #(.CLK_FREQ(CLK_FREQ), .TICK_FREQ(TICK_FREQ)) u_tick (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .tick_o(tick)
  );
  // Descending scan so the smallest offset from ptr wins; MSB flags a hit.
  function automatic logic [IW:0] rr_pick(input logic [N_REQ-1:0] req, input logic [IW-1:0] ptr);
    logic [IW:0] r;
    int j;
    r = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N_REQ;
      if (req[j]) r = {1'b1, IW'(j)};
    end
    return r;
  endfunction
  assign pick = rr_pick(bus.req_i, ptr_q);
  assign idx_nxt = idx_q == IW'(N_REQ - 1) ? '0 : idx_q + 1'b1;
`ifdef TIMER_SCHED_ABORT_EN
  assign abort = state_q == RUN && !bus.req_i[idx_q];
`else
  assign abort = 1'b0;
`endif
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    remain_d = remain_q;
    unique case (state_q)
      IDLE: if (pick[IW]) begin
        state_d  = RUN;
        idx_d    = pick[IW-1:0];
        remain_d = bus.dur_i[pick[IW-1:0]*DUR_W +: DUR_W];
      end
      RUN: if (abort) begin
        state_d  = IDLE;
        remain_d = '0;
        ptr_d    = idx_nxt;
      end else if (remain_q == '0) begin
        state_d = DONE;
      end else if (tick) begin
        remain_d = remain_q - 1'b1;
        state_d  = remain_q == DUR_W'(1) ? DONE : RUN;
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = idx_nxt;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      ptr_q    <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      remain_q <= remain_d;
    end
  assign onehot       = {{(N_REQ-1){1'b0}}, 1'b1} << idx_q;
  assign bus.gnt_o    = state_q == IDLE ? '0 : onehot;
  assign bus.done_o   = state_q == DONE ? onehot : '0;
  assign bus.busy_o   = state_q != IDLE;
  assign bus.tick_o   = tick;
  assign bus.remain_o = remain_q;
endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched: directed checks of timer_sched with PRESC=10 (CLK_FREQ=100, TICK_FREQ=10).
module tb_timer_sched;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   ph;
  logic [3:0] dsum;
  logic [3:0] seq [5];
  timer_sched_if #(.N_REQ(4), .DUR_W(16)) ifc ();
  timer_sched #(.CLK_FREQ(100), .TICK_FREQ(10), .N_REQ(4), .DUR_W(16)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (ifc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // ph mirrors the prescaler phase: posedges since reset release, mod 10.
  task automatic step();
    @(negedge clk);
    ph = (ph + 1) % 10;
  endtask
  task automatic align();
    while (ph != 0) step();
  endtask
  task automatic chk_quiet(input string tag);
    chk(tag, {ifc.gnt_o, ifc.done_o, ifc.busy_o, ifc.tick_o, ifc.remain_o}, 32'h0);
  endtask
  initial begin
    rst_n = 1'b0;
    ifc.req_i = '0;
    ifc.dur_i = '0;
    ph = 0;
    repeat (2) @(negedge clk);
    chk_quiet("reset_outputs");
    rst_n = 1'b1;
    ph = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      chk("t1_tick", 32'(ifc.tick_o), 32'(ph == 9));
      chk("t1_idle", {ifc.gnt_o, ifc.done_o, ifc.busy_o, ifc.remain_o}, 32'h0);
    end
    align();
    ifc.dur_i[0 +: 16] = 16'd3;
    ifc.req_i = 4'b0001;
    step();
    chk("t2_gnt", 32'(ifc.gnt_o), 32'h1);
    chk("t2_rem3", 32'(ifc.remain_o), 32'd3);
    chk("t2_busy", 32'(ifc.busy_o), 32'h1);
    repeat (9) step();
    chk("t2_rem2", 32'(ifc.remain_o), 32'd2);
    repeat (10) step();
    chk("t2_rem1", 32'(ifc.remain_o), 32'd1);
    repeat (9) step();
    chk("t2_no_early_done", {ifc.done_o, ifc.remain_o}, 32'd1);
    step();
    chk("t2_done", 32'(ifc.done_o), 32'h1);
    chk("t2_gnt_in_done", 32'(ifc.gnt_o), 32'h1);
    chk("t2_rem0", 32'(ifc.remain_o), 32'd0);
    ifc.req_i = 4'b0000;
    step();
    chk("t2_idle", {ifc.gnt_o, ifc.done_o, ifc.busy_o}, 32'h0);
    // ptr advanced to 1 after requester 0 finished.
    seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    ifc.dur_i = {16'd1, 16'd1, 16'd1, 16'd1};
    ifc.req_i = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int n = 0; n < 40 && ifc.gnt_o == 4'b0; n++) step();
      chk("t3_gnt", 32'(ifc.gnt_o), 32'(seq[g]));
      for (int n = 0; n < 40 && ifc.done_o == 4'b0; n++) step();
      chk("t3_done", 32'(ifc.done_o), 32'(seq[g]));
      if (g == 4) ifc.req_i = 4'b0000;
      step();
      chk("t3_done_one_cycle", 32'(ifc.done_o), 32'h0);
    end
    ifc.dur_i[32 +: 16] = 16'd0;
    ifc.req_i = 4'b0100;
    step();
    chk("t4_gnt", {ifc.gnt_o, ifc.done_o}, 32'h40);
    step();
    chk("t4_done", 32'(ifc.done_o), 32'h4);
    ifc.req_i = 4'b0000;
    step();
    chk("t4_idle", 32'(ifc.busy_o), 32'h0);
    align();
    ifc.dur_i[16 +: 16] = 16'd5;
    ifc.req_i = 4'b0010;
    step();
    chk("t5_gnt", 32'(ifc.gnt_o), 32'h2);
    chk("t5_rem5", 32'(ifc.remain_o), 32'd5);
    repeat (9) step();
    chk("t5_rem4", 32'(ifc.remain_o), 32'd4);
    repeat (10) step();
    chk("t5_rem3", 32'(ifc.remain_o), 32'd3);
    ifc.req_i = 4'b0000;
    dsum = '0;
`ifdef TIMER_SCHED_ABORT_EN
    step();
    chk("t5_abort", {ifc.gnt_o, ifc.done_o, ifc.busy_o, ifc.remain_o}, 32'h0);
    for (int i = 0; i < 40; i++) begin
      step();
      dsum |= ifc.done_o;
    end
    chk("t5_no_done", 32'(dsum), 32'h0);
`else
    for (int i = 21; i < 50; i++) begin
      step();
      dsum |= ifc.done_o;
    end
    chk("t5_no_early_done", 32'(dsum), 32'h0);
    chk("t5_rem1", 32'(ifc.remain_o), 32'd1);
    step();
    chk("t5_done", 32'(ifc.done_o), 32'h2);
    step();
    chk("t5_idle", 32'(ifc.busy_o), 32'h0);
`endif
    ifc.dur_i = {16'd3, 16'd3, 16'd3, 16'd3};
    ifc.req_i = 4'b0110;
    step();
    chk("t6_gnt_ptr2", 32'(ifc.gnt_o), 32'h4);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1 chk_quiet("t6_async_reset");
    @(negedge clk);
    chk_quiet("t6_in_reset");
    rst_n = 1'b1;
    ph = 0;
    step();
    chk("t6_regrant_ptr0", 32'(ifc.gnt_o), 32'h2);
    repeat (7) step();
    chk("t6_no_tick_yet", 32'(ifc.tick_o), 32'h0);
    step();
    chk("t6_first_tick", 32'(ifc.tick_o), 32'h1);
    ifc.req_i = 4'b0000;
    for (int n = 0; n < 60 && ifc.busy_o; n++) step();
    chk("t6_finish_idle", 32'(ifc.busy_o), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
